edge_detector_multi: RTL and testbench

Parametrised multi-channel edge detector. Each channel synchronises an asynchronous level input, optionally debounces it, and produces registered one-cycle rising/falling pulses plus a mode-filtered event pulse and a sticky pending flag. It sits between raw pins or asynchronous status lines and the interrupt or event logic. It replaces single-bit, unsynchronised edge detection across the design.

---
 rtl/edge_detector_pkg.sv | 17 +
 rtl/edge_channel.sv | 112 +++++++++++
 rtl/edge_detector_multi.sv | 41 ++++
 tb/tb_edge_detector_multi.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/edge_detector_pkg.sv
// Shared constants and helpers for the multi-channel edge detector.
// Optional debounce is enabled by defining EDGE_DEBOUNCE_EN.
package edge_detector_pkg;

    localparam int unsigned MODE_W = 2;

    localparam logic [MODE_W-1:0] EDGE_OFF  = 2'b00;
    localparam logic [MODE_W-1:0] EDGE_RISE = 2'b01;
    localparam logic [MODE_W-1:0] EDGE_FALL = 2'b10;
    localparam logic [MODE_W-1:0] EDGE_BOTH = 2'b11;

    // Debounce counter width: max(1, clog2(cycles)); holds 0..cycles-1.
    function automatic int unsigned cnt_width(input int unsigned cycles);
        return (cycles > 1) ? $clog2(cycles) : 1;
    endfunction

endpackage

// File: rtl/edge_channel.sv
// One edge-detector channel: synchroniser, optional debounce (EDGE_DEBOUNCE_EN),
// accepted level, registered rise/fall pulses, mode-filtered event and sticky pending.
module edge_channel
    import edge_detector_pkg::*;
#(
    parameter int unsigned SYNC_STAGES     = 2,
    parameter int unsigned DEBOUNCE_CYCLES = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              a,
    input  logic [MODE_W-1:0] mode,
    input  logic              clear,
    output logic              level,
    output logic              rise,
    output logic              fall,
    output logic              evt,
    output logic              pending
);

    // Elaboration-time parameter sanity checks.
    if (SYNC_STAGES < 2 || SYNC_STAGES > 4) begin : g_bad_sync
        $error("edge_channel: SYNC_STAGES must be 2..4");
    end
    if (DEBOUNCE_CYCLES < 1) begin : g_bad_debounce
        $error("edge_channel: DEBOUNCE_CYCLES must be >= 1");
    end

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   sync_out;
    logic                   accept;
    logic                   level_q, level_d;
    logic                   rise_q, rise_d;
    logic                   fall_q, fall_d;
    logic                   evt_q, evt_d;
    logic                   pending_q, pending_d;

    assign sync_out = sync_q[SYNC_STAGES-1];

    // Synchroniser shift register; a enters at bit 0.
    always_ff @(posedge clk) begin
        if (reset) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], a};
        end
    end

`ifdef EDGE_DEBOUNCE_EN
    localparam int unsigned   CntW   = cnt_width(DEBOUNCE_CYCLES);
    localparam logic [CntW-1:0] CntMax = CntW'(DEBOUNCE_CYCLES - 1);

    logic [CntW-1:0] cnt_q, cnt_d;

    // Count consecutive mismatching cycles; accept on the last one and restart.
    always_comb begin
        accept = 1'b0;
        cnt_d  = '0;
        if (sync_out != level_q) begin
            if (cnt_q == CntMax) begin
                accept = 1'b1;
            end else begin
                cnt_d = cnt_q + CntW'(1);
            end
        end
    end

    // Debounce counter state.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end
`else
    assign accept = (sync_out != level_q);
`endif

    // Next-state for level, pulses, event and pending; a new event beats a clear.
    always_comb begin
        level_d   = accept ? sync_out : level_q;
        rise_d    = accept & sync_out;
        fall_d    = accept & ~sync_out;
        evt_d     = (rise_d & mode[0]) | (fall_d & mode[1]);
        pending_d = evt_d | (pending_q & ~clear);
    end

    // Output registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            level_q   <= 1'b0;
            rise_q    <= 1'b0;
            fall_q    <= 1'b0;
            evt_q     <= 1'b0;
            pending_q <= 1'b0;
        end else begin
            level_q   <= level_d;
            rise_q    <= rise_d;
            fall_q    <= fall_d;
            evt_q     <= evt_d;
            pending_q <= pending_d;
        end
    end

    assign level   = level_q;
    assign rise    = rise_q;
    assign fall    = fall_q;
    assign evt     = evt_q;
    assign pending = pending_q;

endmodule

// File: rtl/edge_detector_multi.sv
// Multi-channel edge detector top: CHANNELS independent edge_channel instances.
// Debounce is present only when EDGE_DEBOUNCE_EN is defined.
module edge_detector_multi
    import edge_detector_pkg::*;
#(
    parameter int unsigned CHANNELS        = 4,
    parameter int unsigned SYNC_STAGES     = 2,
    parameter int unsigned DEBOUNCE_CYCLES = 8
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [CHANNELS-1:0]        a_i,
    input  logic [MODE_W*CHANNELS-1:0] mode_i,
    input  logic [CHANNELS-1:0]        clear_i,
    output logic [CHANNELS-1:0]        level_o,
    output logic [CHANNELS-1:0]        rising_edge,
    output logic [CHANNELS-1:0]        falling_edge,
    output logic [CHANNELS-1:0]        event_o,
    output logic [CHANNELS-1:0]        pending_o
);

    // One channel per input bit; mode_i is sliced two bits per channel.
    for (genvar k = 0; k < CHANNELS; k++) begin : g_chan
        edge_channel #(
            .SYNC_STAGES    (SYNC_STAGES),
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
        ) u_chan (
            .clk    (clk),
            .reset  (reset),
            .a      (a_i[k]),
            .mode   (mode_i[MODE_W*k +: MODE_W]),
            .clear  (clear_i[k]),
            .level  (level_o[k]),
            .rise   (rising_edge[k]),
            .fall   (falling_edge[k]),
            .evt    (event_o[k]),
            .pending(pending_o[k])
        );
    end

endmodule

// File: tb/tb_edge_detector_multi.sv
// Directed self-checking bench for edge_detector_multi (CHANNELS=4, SYNC_STAGES=2,
// DEBOUNCE_CYCLES=8). Expectations adapt to whether EDGE_DEBOUNCE_EN is defined.
module tb_edge_detector_multi;
    import edge_detector_pkg::*;

`ifdef EDGE_DEBOUNCE_EN
    localparam int LAT = 10;  // SYNC_STAGES + DEBOUNCE_CYCLES
    localparam int PRE = 6;   // edges before reset: debounce count reaches 4
`else
    localparam int LAT = 3;   // SYNC_STAGES + 1
    localparam int PRE = 2;   // reset lands on the pulse edge
`endif

    logic       clk;
    logic       reset;
    logic [3:0] a_i;
    logic [7:0] mode_i;
    logic [3:0] clear_i;
    logic [3:0] level_o, rising_edge, falling_edge, event_o, pending_o;

    int passed = 0;
    int total  = 0;

    edge_detector_multi #(
        .CHANNELS       (4),
        .SYNC_STAGES    (2),
        .DEBOUNCE_CYCLES(8)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .a_i         (a_i),
        .mode_i      (mode_i),
        .clear_i     (clear_i),
        .level_o     (level_o),
        .rising_edge (rising_edge),
        .falling_edge(falling_edge),
        .event_o     (event_o),
        .pending_o   (pending_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_all();
        clear_i = 4'hF;
        tick();
        clear_i = 4'h0;
    endtask

    task automatic test_reset();
        reset   = 1'b1;
        a_i     = 4'h0;
        mode_i  = 8'hFF;
        clear_i = 4'h0;
        repeat (3) tick();
        reset = 1'b0;
        tick();
        total++; if (level_o !== 4'h0) $display("FAIL reset_level got %b want 0000", level_o); else passed++;
        total++; if (rising_edge !== 4'h0 || falling_edge !== 4'h0)
            $display("FAIL reset_pulses got %b/%b want 0000/0000", rising_edge, falling_edge); else passed++;
        total++; if (event_o !== 4'h0 || pending_o !== 4'h0)
            $display("FAIL reset_evt_pend got %b/%b want 0000/0000", event_o, pending_o); else passed++;
    endtask

    task automatic test_rise_fall();
        logic [3:0] er, el, ep;
        a_i = 4'b0001;
        for (int n = 1; n <= LAT + 2; n++) begin
            tick();
            er = (n == LAT) ? 4'b0001 : 4'b0000;
            el = (n >= LAT) ? 4'b0001 : 4'b0000;
            ep = el;
            total++; if (rising_edge !== er) $display("FAIL rise_pulse n=%0d got %b want %b", n, rising_edge, er); else passed++;
            total++; if (level_o !== el) $display("FAIL rise_level n=%0d got %b want %b", n, level_o, el); else passed++;
            total++; if (event_o !== er) $display("FAIL rise_event n=%0d got %b want %b", n, event_o, er); else passed++;
            total++; if (pending_o !== ep) $display("FAIL rise_pending n=%0d got %b want %b", n, pending_o, ep); else passed++;
            total++; if (falling_edge !== 4'h0) $display("FAIL rise_nofall n=%0d got %b want 0000", n, falling_edge); else passed++;
        end
        clear_i = 4'b0001;
        tick();
        clear_i = 4'b0000;
        total++; if (pending_o !== 4'h0) $display("FAIL clear_pending got %b want 0000", pending_o); else passed++;
        a_i = 4'b0000;
        for (int n = 1; n <= LAT + 2; n++) begin
            tick();
            er = (n == LAT) ? 4'b0001 : 4'b0000;
            el = (n < LAT) ? 4'b0001 : 4'b0000;
            ep = (n >= LAT) ? 4'b0001 : 4'b0000;
            total++; if (falling_edge !== er) $display("FAIL fall_pulse n=%0d got %b want %b", n, falling_edge, er); else passed++;
            total++; if (level_o !== el) $display("FAIL fall_level n=%0d got %b want %b", n, level_o, el); else passed++;
            total++; if (pending_o !== ep) $display("FAIL fall_pending n=%0d got %b want %b", n, pending_o, ep); else passed++;
            total++; if (rising_edge !== 4'h0) $display("FAIL fall_norise n=%0d got %b want 0000", n, rising_edge); else passed++;
        end
        clear_all();
    endtask

    task automatic test_glitch();
        logic [3:0] er, ef;
`ifdef EDGE_DEBOUNCE_EN
        // Five-cycle pulse on channel 1 is shorter than the debounce window.
        for (int n = 1; n <= 17; n++) begin
            a_i = (n <= 5) ? 4'b0010 : 4'b0000;
            tick();
            total++; if (rising_edge !== 4'h0 || level_o !== 4'h0)
                $display("FAIL glitch_filtered n=%0d rise=%b level=%b want 0000/0000", n, rising_edge, level_o); else passed++;
        end
        a_i = 4'b0010;
        for (int n = 1; n <= LAT + 1; n++) begin
            tick();
            er = (n == LAT) ? 4'b0010 : 4'b0000;
            total++; if (rising_edge !== er) $display("FAIL debounce_rise n=%0d got %b want %b", n, rising_edge, er); else passed++;
        end
        a_i = 4'b0000;
        repeat (LAT + 2) tick();
`else
        // Single-cycle pulse on channel 1 passes straight through.
        a_i = 4'b0010;
        for (int n = 1; n <= LAT + 3; n++) begin
            tick();
            a_i = 4'b0000;
            er = (n == LAT)     ? 4'b0010 : 4'b0000;
            ef = (n == LAT + 1) ? 4'b0010 : 4'b0000;
            total++; if (rising_edge !== er) $display("FAIL glitch_rise n=%0d got %b want %b", n, rising_edge, er); else passed++;
            total++; if (falling_edge !== ef) $display("FAIL glitch_fall n=%0d got %b want %b", n, falling_edge, ef); else passed++;
        end
`endif
        clear_all();
    endtask

    task automatic test_mode();
        logic [3:0] er, ee, ep;
        // ch3 both, ch2 fall only, ch1 both, ch0 off
        mode_i = {EDGE_BOTH, EDGE_FALL, EDGE_BOTH, EDGE_OFF};
        a_i    = 4'b0101;
        for (int n = 1; n <= LAT + 1; n++) begin
            tick();
            er = (n == LAT) ? 4'b0101 : 4'b0000;
            total++; if (rising_edge !== er) $display("FAIL mode_rise n=%0d got %b want %b", n, rising_edge, er); else passed++;
            total++; if (event_o !== 4'h0) $display("FAIL mode_rise_event n=%0d got %b want 0000", n, event_o); else passed++;
            total++; if (pending_o !== 4'h0) $display("FAIL mode_rise_pending n=%0d got %b want 0000", n, pending_o); else passed++;
        end
        a_i = 4'b0000;
        for (int n = 1; n <= LAT + 1; n++) begin
            tick();
            er = (n == LAT) ? 4'b0101 : 4'b0000;
            ee = (n == LAT) ? 4'b0100 : 4'b0000;
            ep = (n >= LAT) ? 4'b0100 : 4'b0000;
            total++; if (falling_edge !== er) $display("FAIL mode_fall n=%0d got %b want %b", n, falling_edge, er); else passed++;
            total++; if (event_o !== ee) $display("FAIL mode_fall_event n=%0d got %b want %b", n, event_o, ee); else passed++;
            total++; if (pending_o !== ep) $display("FAIL mode_fall_pending n=%0d got %b want %b", n, pending_o, ep); else passed++;
        end
        mode_i = 8'hFF;
        clear_all();
    endtask

    task automatic test_set_clear();
        a_i = 4'b1000;
        repeat (LAT) tick();
        total++; if (pending_o !== 4'b1000) $display("FAIL sc_preset got %b want 1000", pending_o); else passed++;
        a_i = 4'b0000;
        repeat (LAT - 1) tick();
        clear_i = 4'b1000;
        tick();
        total++; if (falling_edge !== 4'b1000 || event_o !== 4'b1000)
            $display("FAIL sc_event fall=%b evt=%b want 1000/1000", falling_edge, event_o); else passed++;
        total++; if (pending_o !== 4'b1000) $display("FAIL sc_set_wins got %b want 1000", pending_o); else passed++;
        clear_i = 4'b0000;
        tick();
        total++; if (pending_o !== 4'b1000) $display("FAIL sc_hold got %b want 1000", pending_o); else passed++;
        clear_i = 4'b1000;
        tick();
        total++; if (pending_o !== 4'b0000) $display("FAIL sc_clear got %b want 0000", pending_o); else passed++;
        tick();
        clear_i = 4'b0000;
        total++; if (pending_o !== 4'b0000 || level_o !== 4'b0000)
            $display("FAIL sc_idle_clear pend=%b level=%b want 0000/0000", pending_o, level_o); else passed++;
    endtask

    task automatic test_back_to_back();
        logic [3:0] er, ef, el;
`ifdef EDGE_DEBOUNCE_EN
        // Alternating input never persists long enough to be accepted.
        for (int n = 1; n <= 12; n++) begin
            a_i = n[0] ? 4'b0001 : 4'b0000;
            tick();
            total++; if (rising_edge !== 4'h0 || level_o !== 4'h0)
                $display("FAIL b2b_filtered n=%0d rise=%b level=%b want 0000/0000", n, rising_edge, level_o); else passed++;
        end
        a_i = 4'b0000;
        repeat (4) tick();
`else
        // Input toggles every cycle: every toggle becomes an accepted edge.
        for (int n = 1; n <= 8; n++) begin
            a_i = (n <= 4 && n[0]) ? 4'b0001 : 4'b0000;
            tick();
            er = (n == 3 || n == 5) ? 4'b0001 : 4'b0000;
            ef = (n == 4 || n == 6) ? 4'b0001 : 4'b0000;
            el = (n == 3 || n == 5) ? 4'b0001 : 4'b0000;
            total++; if (rising_edge !== er) $display("FAIL b2b_rise n=%0d got %b want %b", n, rising_edge, er); else passed++;
            total++; if (falling_edge !== ef) $display("FAIL b2b_fall n=%0d got %b want %b", n, falling_edge, ef); else passed++;
            total++; if (level_o !== el) $display("FAIL b2b_level n=%0d got %b want %b", n, level_o, el); else passed++;
        end
`endif
        clear_all();
    endtask

    task automatic test_reset_high();
        logic [3:0] er, el;
        reset = 1'b1;
        a_i   = 4'hF;
        repeat (3) tick();
        total++; if (level_o !== 4'h0 || rising_edge !== 4'h0)
            $display("FAIL rsthigh_in_reset level=%b rise=%b want 0000/0000", level_o, rising_edge); else passed++;
        reset = 1'b0;
        for (int n = 1; n <= LAT + 3; n++) begin
            tick();
            er = (n == LAT) ? 4'hF : 4'h0;
            el = (n >= LAT) ? 4'hF : 4'h0;
            total++; if (rising_edge !== er) $display("FAIL rsthigh_rise n=%0d got %b want %b", n, rising_edge, er); else passed++;
            total++; if (falling_edge !== 4'h0) $display("FAIL rsthigh_nofall n=%0d got %b want 0000", n, falling_edge); else passed++;
            total++; if (level_o !== el) $display("FAIL rsthigh_level n=%0d got %b want %b", n, level_o, el); else passed++;
        end
    endtask

    task automatic test_reset_mid();
        logic [3:0] er;
        reset = 1'b1;
        a_i   = 4'h0;
        repeat (2) tick();
        reset = 1'b0;
        a_i   = 4'b0010;
        repeat (PRE) tick();
        reset = 1'b1;
        tick();
        total++; if (rising_edge !== 4'h0 || level_o !== 4'h0 || pending_o !== 4'h0)
            $display("FAIL rstmid_forced rise=%b level=%b pend=%b want all 0000",
                     rising_edge, level_o, pending_o); else passed++;
        reset = 1'b0;
        for (int n = 1; n <= LAT + 1; n++) begin
            tick();
            er = (n == LAT) ? 4'b0010 : 4'b0000;
            total++; if (rising_edge !== er) $display("FAIL rstmid_rise n=%0d got %b want %b", n, rising_edge, er); else passed++;
        end
    endtask

    initial begin
        test_reset();
        test_rise_fall();
        test_glitch();
        test_mode();
        test_set_clear();
        test_back_to_back();
        test_reset_high();
        test_reset_mid();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
